// File: rtl/chunked_add_pkg.sv
// Shared types and helpers for the chunked adder sequencer.
// Optional subtract support lives in the top and is enabled by ADD_SUB_EN.
package chunked_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // The chunk index is at least one bit wide, so a single-chunk build still has a counter.
    function automatic int unsigned idx_width(input int unsigned nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/add_chunk.sv
// CHUNK_W-bit ripple adder slice with carry in and carry out.
// This is the only arithmetic in the sequencer, and it is shared across all chunks.
module add_chunk #(
    parameter int unsigned CHUNK_W = 8
) (
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               cin,
    output logic [CHUNK_W-1:0] sum,
    output logic               cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, cin};

endmodule

// File: rtl/chunked_add_sequencer.sv
// Multi-cycle DATA_W adder that reuses one CHUNK_W slice over NCHUNK cycles.
// Define ADD_SUB_EN to add the in_sub port and the a + ~b + 1 subtract path.
module chunked_add_sequencer
    import chunked_add_pkg::*;
#(
    parameter int unsigned CHUNK_W = 8,
    parameter int unsigned NCHUNK  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHUNK_W*NCHUNK-1:0]   in_a,
    input  logic [CHUNK_W*NCHUNK-1:0]   in_b,
`ifdef ADD_SUB_EN
    input  logic                        in_sub,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CHUNK_W*NCHUNK-1:0]   out_sum,
    output logic                        out_cout,
    output logic                        busy
);

    localparam int unsigned DATA_W = CHUNK_W * NCHUNK;
    localparam int unsigned IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                carry_q, carry_d;

    logic [CHUNK_W-1:0]  a_chunk, b_chunk, chunk_sum;
    logic                chunk_cout;

    assign a_chunk = a_q[idx_q*CHUNK_W +: CHUNK_W];
    assign b_chunk = b_q[idx_q*CHUNK_W +: CHUNK_W];

    add_chunk #(
        .CHUNK_W (CHUNK_W)
    ) u_add_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    idx_d   = '0;
`ifdef ADD_SUB_EN
                    // Subtraction as a + ~b + 1: invert B once here, seed the carry with 1.
                    b_d     = in_b ^ {DATA_W{in_sub}};
                    carry_d = in_sub;
`else
                    b_d     = in_b;
                    carry_d = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*CHUNK_W +: CHUNK_W] = chunk_sum;
                carry_d = chunk_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Directed and random checks of chunked_add_sequencer against an arithmetic reference model.
// Subtract scenarios run only when ADD_SUB_EN is defined.
module tb_chunked_add_sequencer;

    localparam int unsigned CW  = 8;
    localparam int unsigned NC  = 4;
    localparam int unsigned DW  = CW * NC;
    localparam int unsigned CW1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, out_cout, busy;
    logic [DW-1:0] in_a, in_b, out_sum;
`ifdef ADD_SUB_EN
    logic          in_sub;
    logic          in_sub1;
`endif

    logic           in_valid1, in_ready1, out_valid1, out_ready1, out_cout1, busy1;
    logic [CW1-1:0] in_a1, in_b1, out_sum1;

    int checks   = 0;
    int failures = 0;

    chunked_add_sequencer #(
        .CHUNK_W (CW),
        .NCHUNK  (NC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef ADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    chunked_add_sequencer #(
        .CHUNK_W (CW1),
        .NCHUNK  (1)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_a      (in_a1),
        .in_b      (in_b1),
`ifdef ADD_SUB_EN
        .in_sub    (in_sub1),
`endif
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_sum   (out_sum1),
        .out_cout  (out_cout1),
        .busy      (busy1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the 8x4 instance; junk is driven on the inputs while busy.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub,
                          input int hold, input string tag);
        logic [DW:0] full;
        int          cnt;
        full = sub ? ({1'b0, a} + {1'b0, ~b} + (DW+1)'(1)) : ({1'b0, a} + {1'b0, b});
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
`ifdef ADD_SUB_EN
        in_sub    = sub;
`endif
        out_ready = 1'b0;
        check({tag, ":in_ready_at_accept"}, 64'(in_ready), 64'd1);
        step();
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            check({tag, ":in_ready_run"}, 64'(in_ready), 64'd0);
            in_valid = 1'($urandom);
            in_a     = $urandom;
            in_b     = $urandom;
`ifdef ADD_SUB_EN
            in_sub   = 1'($urandom);
`endif
            step();
            cnt++;
        end
        check({tag, ":latency"}, 64'(cnt + 1), 64'(NC + 1));
        for (int i = 0; i <= hold; i++) begin
            check({tag, ":out_valid"}, 64'(out_valid), 64'd1);
            check({tag, ":out_sum"}, 64'(out_sum), 64'(full[DW-1:0]));
            check({tag, ":out_cout"}, 64'(out_cout), 64'(full[DW]));
            check({tag, ":in_ready_done"}, 64'(in_ready), 64'd0);
            check({tag, ":busy_done"}, 64'(busy), 64'd1);
            if (i < hold) begin
                in_valid = 1'($urandom);
                in_a     = $urandom;
                step();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ":in_ready_after"}, 64'(in_ready), 64'd1);
        check({tag, ":out_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run_op1(input logic [CW1-1:0] a, input logic [CW1-1:0] b, input string tag);
        logic [CW1:0] full;
        int           cnt;
        full       = {1'b0, a} + {1'b0, b};
        in_valid1  = 1'b1;
        in_a1      = a;
        in_b1      = b;
        out_ready1 = 1'b0;
        check({tag, ":in_ready_at_accept"}, 64'(in_ready1), 64'd1);
        step();
        in_valid1 = 1'b0;
        cnt = 0;
        while (!out_valid1 && cnt < 20) begin
            step();
            cnt++;
        end
        check({tag, ":latency"}, 64'(cnt + 1), 64'd2);
        check({tag, ":out_sum"}, 64'(out_sum1), 64'(full[CW1-1:0]));
        check({tag, ":out_cout"}, 64'(out_cout1), 64'(full[CW1]));
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        check({tag, ":in_ready_after"}, 64'(in_ready1), 64'd1);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_a1      = '0;
        in_b1      = '0;
        out_ready1 = 1'b0;
`ifdef ADD_SUB_EN
        in_sub     = 1'b0;
        in_sub1    = 1'b0;
`endif
        step();
        step();
        check("reset:in_ready", 64'(in_ready), 64'd1);
        check("reset:out_valid", 64'(out_valid), 64'd0);
        check("reset:busy", 64'(busy), 64'd0);
        check("reset:out_sum", 64'(out_sum), 64'd0);
        check("reset:out_cout", 64'(out_cout), 64'd0);
        check("reset1:in_ready", 64'(in_ready1), 64'd1);
        rst = 1'b0;
        step();

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, "ff_plus_1");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3, "wrap_backpressure");
        run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 0, "back_to_back");
`ifdef ADD_SUB_EN
        run_op(32'd5, 32'd7, 1'b1, 0, "sub_5_7");
        run_op(32'd7, 32'd5, 1'b1, 1, "sub_7_5");
`endif

        // Reset and in_valid together: nothing may be accepted.
        in_valid = 1'b1;
        in_a     = 32'h1;
        in_b     = 32'h1;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_vs_valid:busy", 64'(busy), 64'd0);
        step();
        check("rst_vs_valid:busy_next", 64'(busy), 64'd0);
        check("rst_vs_valid:out_valid", 64'(out_valid), 64'd0);

        // Reset in the second RUN cycle drops the operation.
        in_valid = 1'b1;
        in_a     = 32'h1234_5678;
        in_b     = 32'h1111_1111;
        step();
        in_valid = 1'b0;
        check("mid_rst:busy_run", 64'(busy), 64'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst:in_ready", 64'(in_ready), 64'd1);
        check("mid_rst:out_valid", 64'(out_valid), 64'd0);
        check("mid_rst:busy", 64'(busy), 64'd0);
        check("mid_rst:out_sum", 64'(out_sum), 64'd0);
        check("mid_rst:out_cout", 64'(out_cout), 64'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("mid_rst:no_out_valid", 64'(out_valid), 64'd0);
        end
        run_op(32'd1, 32'd2, 1'b0, 0, "after_rst_1_plus_2");

        for (int i = 0; i < 10; i++) begin
            logic sub;
`ifdef ADD_SUB_EN
            sub = 1'($urandom);
`else
            sub = 1'b0;
`endif
            run_op($urandom, $urandom, sub, int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
        end

        run_op1(4'hF, 4'h1, "n1_f_plus_1");
        for (int i = 0; i < 8; i++) begin
            run_op1(4'($urandom), 4'($urandom), $sformatf("n1_rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chunked_add_sequencer.md
# chunked_add_sequencer

Multi-cycle adder controller. It computes a DATA_W-bit sum by sequencing a single CHUNK_W-bit ripple adder over NCHUNK consecutive cycles, carrying between chunks through a register. This trades latency for area when a full-width ripple adder is too slow or too large. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

## Interface

Parameters:
- CHUNK_W, 8: width of the shared adder slice; must be ≥1.
- NCHUNK, 4: number of chunks; must be ≥1. DATA_W = CHUNK_W*NCHUNK, a localparam.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- in_sub  in  1  subtract request; exists only with ADD_SUB_EN.
- out_valid  out  1  result held on out_sum/out_cout.
- out_ready  in  1  consumer accepts result.
- out_sum  out  DATA_W  sum, or difference when subtracting.
- out_cout  out  1  carry out of the MSB chunk; for subtraction, 1 means no borrow.
- busy  out  1  high in RUN or DONE.

## Operation

- States: IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready:
    - latch in_a → a_q and in_b → b_q (b_q is inverted if subtracting);
    - carry_q=0, or 1 if subtracting;
    - idx=0;
    - go to RUN.
- **RUN**
  - Each cycle, the chunk adder computes a_q[idx] + b_q[idx] + carry_q.
  - Sum chunk is written to sum_q[idx*CHUNK_W +: CHUNK_W]; chunk carry → carry_q; idx++.
  - When idx==NCHUNK-1 this cycle, go to DONE.
  - idx is clog2(NCHUNK) wide, minimum 1 bit; it never wraps past NCHUNK-1.
- **DONE**
  - out_valid=1; out_sum=sum_q; out_cout=carry_q.
  - On out_ready, go to IDLE.
  - Outputs stay stable while out_ready=0.
- No overlap: in_ready=0 in RUN and DONE. Operands presented then are ignored, not queued.
- Input changes after acceptance do not affect the result.
- Arithmetic is modulo 2^DATA_W; the carry beyond out_cout is discarded.
- Reset, at any time including mid-RUN or in DONE:
  - state=IDLE, in_ready=1, out_valid=0, busy=0;
  - out_sum=0, out_cout=0, idx=0, carry_q=0.
  - The in-flight operation is dropped with no output.
- in_valid and rst asserted in the same cycle: reset wins; nothing is accepted.

## Timing

- Accept edge at end of cycle t → RUN during cycles t+1 … t+NCHUNK.
- out_valid rises at cycle t+NCHUNK+1.
- Latency = NCHUNK+1 cycles from accept to out_valid; with NCHUNK=1 it is 2.
- Result handshake at end of cycle u → in_ready=1 at cycle u+1.
- Minimum issue interval: NCHUNK+2 cycles.
- Critical path: one CHUNK_W ripple plus the sum_q write-enable decode. No path is full-width.
- All outputs are registered or decoded directly from state. There are no combinational paths from inputs to outputs.

## Configuration

- ADD_SUB_EN defined:
  - in_sub port exists and is sampled at accept.
  - Subtraction computes in_a − in_b as a + ~b + 1.
- ADD_SUB_EN undefined:
  - in_sub port is absent.
  - Operation is add only, carry_q initialises to 0, and the inversion logic is absent.

## Structure

- Shared package chunked_add_pkg contains:
  - state enum {IDLE, RUN, DONE};
  - a function computing idx width from NCHUNK.
- Sub-module add_chunk (CHUNK_W-bit adder with cin/cout) is instantiated exactly once. It is the only arithmetic in the block.
- Chunk selection is done by an idx-indexed part-select mux on a_q and b_q.

## Test plan

All scenarios use CHUNK_W=8, NCHUNK=4 unless noted.

- 0x000000FF + 0x00000001 → out_sum=0x00000100, out_cout=0; out_valid exactly 5 cycles after accept.
- 0xFFFFFFFF + 0x00000001 → out_sum=0x00000000, out_cout=1; in_ready=0 for all cycles until the result handshake.
- ADD_SUB_EN, 5 − 7 → out_sum=0xFFFFFFFE, out_cout=0; 7 − 5 → out_sum=0x00000002, out_cout=1.
- Backpressure:
  - hold out_ready=0 for 3 cycles in DONE → out_sum and out_cout stable, out_valid stays 1;
  - in_valid toggled during RUN/DONE is ignored;
  - after the handshake, next accept is at the earliest 1 cycle later.
- Assert rst in the 2nd RUN cycle of 0x12345678 + 0x11111111 → next cycle IDLE, all outputs 0, no out_valid. A new op 1 + 2 → 3 with normal latency.
- NCHUNK=1, CHUNK_W=4: 0xF + 0x1 → out_sum=0x0, out_cout=1 at latency 2. Random back-to-back ops match the reference model a+b.
